// File: rtl/block_batcher_if.sv
// ----------------------------------------------------------------------------
// block_batcher_if
// Bundles both valid/ready streams of the block batcher.
//   in_data/in_valid/in_last/in_ready  : word stream from the byte receiver
//   out_data/out_valid/out_ready       : block stream towards the AES core
//   out_last                           : head block closes a message
//   out_words                          : data (non-pad) words in the head block
// Modports:
//   slave  - the batcher itself (consumes words, produces blocks)
//   master - whatever drives words in and takes blocks out
// ----------------------------------------------------------------------------
interface block_batcher_if #(
   parameter int WORD_W  = 8,
   parameter int BLOCK_W = 128
);
   localparam int WORDS = BLOCK_W / WORD_W;
   localparam int OW    = $clog2(WORDS + 1);

   logic [WORD_W-1:0]  in_data;
   logic               in_valid;
   logic               in_last;
   logic               in_ready;
   logic [BLOCK_W-1:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   logic [OW-1:0]      out_words;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, out_words
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_words
   );
endinterface

// File: rtl/block_batcher.sv
// ----------------------------------------------------------------------------
// block_batcher
// Packs WORD_W-bit words into BLOCK_W-bit blocks and queues up to DEPTH
// finished blocks. A word flagged in_last closes the current block early;
// the unused slots are zero filled (PAD_MODE=0) or filled with PKCS#7-style
// pad bytes (PAD_MODE=1). LSB_FIRST selects whether the first word lands in
// the most- or least-significant slot.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - block_batcher_if.slave carrying the word and block streams
// ----------------------------------------------------------------------------
module block_batcher #(
   parameter int WORD_W    = 8,
   parameter int BLOCK_W   = 128,
   parameter int DEPTH     = 2,
   parameter int PAD_MODE  = 0,
   parameter int LSB_FIRST = 0
) (
   input logic            clk,
   input logic            reset,
   block_batcher_if.slave bus
);
   localparam int WORDS = BLOCK_W / WORD_W;
   localparam int BYTES = WORD_W / 8;
   localparam int CNT_W = $clog2(WORDS);
   localparam int OW    = $clog2(WORDS + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FC_W  = $clog2(DEPTH + 1);

   logic [CNT_W-1:0]   cnt;
   logic [BLOCK_W-1:0] asm_q;
   logic [BLOCK_W-1:0] blk_next;
   logic [7:0]         pad_byte;
   logic               accept;
   logic               complete;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;

   logic [BLOCK_W-1:0] mem_data  [DEPTH];
   logic               mem_last  [DEPTH];
   logic [OW-1:0]      mem_words [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [FC_W-1:0]    fifo_count;

   // Low bit of slot i; slot 0 is the first word of a block.
   function automatic int slot_lo(input int i);
      return (LSB_FIRST != 0) ? i * WORD_W : (WORDS - 1 - i) * WORD_W;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // in_ready comes from the registered count only, so a full FIFO stalls
   // every word, even ones that would not complete a block.
   assign fifo_full     = (fifo_count == FC_W'(DEPTH));
   assign fifo_empty    = (fifo_count == '0);
   assign bus.in_ready  = !fifo_full;
   assign bus.out_valid = !fifo_empty;

   assign accept   = bus.in_valid && !fifo_full;
   assign complete = accept && ((cnt == CNT_W'(WORDS - 1)) || bus.in_last);
   assign pop      = !fifo_empty && bus.out_ready;

   // Block as it would look with the current word merged in. The assembly
   // register keeps unused slots at zero, so zero fill needs no extra work;
   // PKCS#7 fill only touches slots beyond the closing word.
   always_comb begin
      pad_byte = 8'((WORDS - 1 - int'(cnt)) * BYTES);
      blk_next = asm_q;
      for (int i = 0; i < WORDS; i++) begin
         if (int'(cnt) == i)
            blk_next[slot_lo(i) +: WORD_W] = bus.in_data;
         else if ((PAD_MODE == 1) && bus.in_last && (i > int'(cnt)))
            blk_next[slot_lo(i) +: WORD_W] = {BYTES{pad_byte}};
      end
   end

   // Assembly register: restarts empty after every completed block.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         asm_q <= '0;
      end else if (accept) begin
         if (complete) begin
            cnt   <= '0;
            asm_q <= '0;
         end else begin
            cnt   <= cnt + CNT_W'(1);
            asm_q <= blk_next;
         end
      end
   end

   // FIFO storage; entries are only visible through the valid-gated outputs,
   // so they need no reset.
   always_ff @(posedge clk) begin
      if (complete) begin
         mem_data[wr_ptr]  <= blk_next;
         mem_last[wr_ptr]  <= bus.in_last;
         mem_words[wr_ptr] <= OW'(cnt) + OW'(1);
      end
   end

   // FIFO pointers and occupancy; push and pop on one edge cancel out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (complete)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         if (complete && !pop)
            fifo_count <= fifo_count + FC_W'(1);
         else if (pop && !complete)
            fifo_count <= fifo_count - FC_W'(1);
      end
   end

   assign bus.out_data  = fifo_empty ? '0 : mem_data[rd_ptr];
   assign bus.out_last  = fifo_empty ? 1'b0 : mem_last[rd_ptr];
   assign bus.out_words = fifo_empty ? '0 : mem_words[rd_ptr];
endmodule

// File: tb/tb_block_batcher.sv
// ----------------------------------------------------------------------------
// tb_block_batcher
// Three batchers with different parameter sets share one clock and reset:
//   u_dut0 - defaults (8-bit words, zero pad, MSB first, DEPTH 2)
//   u_dut1 - PKCS#7 padding, otherwise default
//   u_dut2 - 32-bit words, LSB first, PKCS#7 padding, DEPTH 1
// Stimulus pushes hand-computed blocks into per-DUT queues; monitors pop and
// compare whenever a block is handed over.
// ----------------------------------------------------------------------------
module tb_block_batcher;
   typedef struct {
      logic [127:0] data;
      logic         last;
      int           words;
   } blk_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   blk_t sb0[$];
   blk_t sb1[$];
   blk_t sb2[$];
   blk_t e0, e1, e2;

   logic [127:0] hold0_data;
   logic         hold0_valid = 1'b0;

   always #5 clk = ~clk;

   block_batcher_if #(.WORD_W(8),  .BLOCK_W(128)) bus0 ();
   block_batcher_if #(.WORD_W(8),  .BLOCK_W(128)) bus1 ();
   block_batcher_if #(.WORD_W(32), .BLOCK_W(128)) bus2 ();

   block_batcher u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   block_batcher #(.PAD_MODE(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   block_batcher #(
      .WORD_W(32), .BLOCK_W(128), .DEPTH(1), .PAD_MODE(1), .LSB_FIRST(1)
   ) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      n_checks++;
      if (actual === expected)
         n_pass++;
      else
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   function automatic blk_t mk(input logic [127:0] d, input logic l, input int w);
      blk_t b;
      b.data  = d;
      b.last  = l;
      b.words = w;
      return b;
   endfunction

   // Sixteen consecutive byte values, first one in the top byte.
   function automatic logic [127:0] bytes_blk(input int first);
      logic [127:0] r;
      r = '0;
      for (int j = 0; j < 16; j++)
         r[127 - 8*j -: 8] = 8'(first + j);
      return r;
   endfunction

   function automatic logic readyOf(input int d);
      case (d)
         0:       return bus0.in_ready;
         1:       return bus1.in_ready;
         default: return bus2.in_ready;
      endcase
   endfunction

   // Called just after a falling edge; returns just after the falling edge
   // that follows the accepting rising edge.
   task automatic applyStimulus(input int d, input logic [31:0] word, input logic last);
      int   waited;
      logic rdy;
      waited = 0;
      case (d)
         0: begin bus0.in_data = word[7:0]; bus0.in_last = last; bus0.in_valid = 1'b1; end
         1: begin bus1.in_data = word[7:0]; bus1.in_last = last; bus1.in_valid = 1'b1; end
         default: begin bus2.in_data = word; bus2.in_last = last; bus2.in_valid = 1'b1; end
      endcase
      rdy = readyOf(d);
      while (!rdy && waited < 200) begin
         @(negedge clk);
         waited++;
         rdy = readyOf(d);
      end
      if (!rdy) begin
         n_checks++;
         $display("[TB] FAIL accept_timeout dut%0d: in_ready stayed 0, word %h never taken", d, word);
      end else begin
         @(posedge clk);
      end
      @(negedge clk);
      case (d)
         0: begin bus0.in_valid = 1'b0; bus0.in_last = 1'b0; end
         1: begin bus1.in_valid = 1'b0; bus1.in_last = 1'b0; end
         default: begin bus2.in_valid = 1'b0; bus2.in_last = 1'b0; end
      endcase
   endtask

   task automatic drainWait(input string name);
      int guard;
      guard = 0;
      while ((sb0.size() + sb1.size() + sb2.size()) != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput({name, "_drained"}, 128'(sb0.size() + sb1.size() + sb2.size()), 128'd0);
      @(negedge clk);
   endtask

   // Scoreboard monitors: compare the head block on every pop.
   always @(negedge clk) begin
      #1;
      if (bus0.out_valid && bus0.out_ready) begin
         if (sb0.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL dut0_unexpected_block: got %h, expected no block", bus0.out_data);
         end else begin
            e0 = sb0.pop_front();
            checkOutput("dut0_data",  bus0.out_data, e0.data);
            checkOutput("dut0_last",  128'(bus0.out_last), 128'(e0.last));
            checkOutput("dut0_words", 128'(bus0.out_words), 128'(e0.words));
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (bus1.out_valid && bus1.out_ready) begin
         if (sb1.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL dut1_unexpected_block: got %h, expected no block", bus1.out_data);
         end else begin
            e1 = sb1.pop_front();
            checkOutput("dut1_data",  bus1.out_data, e1.data);
            checkOutput("dut1_last",  128'(bus1.out_last), 128'(e1.last));
            checkOutput("dut1_words", 128'(bus1.out_words), 128'(e1.words));
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (bus2.out_valid && bus2.out_ready) begin
         if (sb2.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL dut2_unexpected_block: got %h, expected no block", bus2.out_data);
         end else begin
            e2 = sb2.pop_front();
            checkOutput("dut2_data",  bus2.out_data, e2.data);
            checkOutput("dut2_last",  128'(bus2.out_last), 128'(e2.last));
            checkOutput("dut2_words", 128'(bus2.out_words), 128'(e2.words));
         end
      end
   end

   // A stalled head block must not change until it is taken.
   always @(negedge clk) begin
      #1;
      if (hold0_valid && bus0.out_valid)
         checkOutput("dut0_hold_stable", bus0.out_data, hold0_data);
      hold0_valid = bus0.out_valid && !bus0.out_ready;
      hold0_data  = bus0.out_data;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0;
      bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.in_last = 1'b0; bus0.out_ready = 1'b0;
      bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;
      bus2.in_data = '0; bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.out_ready = 1'b1;
      repeat (2) @(negedge clk);

      checkOutput("rst_out_valid", 128'(bus0.out_valid), 128'd0);
      checkOutput("rst_out_data",  bus0.out_data, 128'd0);
      checkOutput("rst_out_words", 128'(bus0.out_words), 128'd0);
      checkOutput("rst_in_ready",  128'(bus0.in_ready), 128'd1);
      reset = 1'b1;
      @(negedge clk);

      // Full block at full rate
      bus0.out_ready = 1'b1;
      sb0.push_back(mk(128'h000102030405060708090A0B0C0D0E0F, 1'b0, 16));
      for (int i = 0; i < 15; i++)
         applyStimulus(0, 32'(i), 1'b0);
      checkOutput("full_no_early_valid", 128'(bus0.out_valid), 128'd0);
      applyStimulus(0, 32'h0F, 1'b0);
      checkOutput("full_valid_after_last", 128'(bus0.out_valid), 128'd1);
      drainWait("full");

      // Partial block, zero fill
      sb0.push_back(mk(128'hC1C2C300000000000000000000000000, 1'b1, 3));
      applyStimulus(0, 32'hC1, 1'b0);
      applyStimulus(0, 32'hC2, 1'b0);
      applyStimulus(0, 32'hC3, 1'b1);
      drainWait("zero_pad");

      // Backpressure: 48 bytes into a 2-deep FIFO with the consumer stalled
      bus0.out_ready = 1'b0;
      sb0.push_back(mk(bytes_blk(8'h30), 1'b0, 16));
      sb0.push_back(mk(bytes_blk(8'h40), 1'b0, 16));
      sb0.push_back(mk(bytes_blk(8'h50), 1'b0, 16));
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, 32'h30 + 32'(i), 1'b0);
         if (i == 15)
            checkOutput("bp_ready_one_buffered", 128'(bus0.in_ready), 128'd1);
      end
      checkOutput("bp_ready_low_when_full", 128'(bus0.in_ready), 128'd0);
      checkOutput("bp_valid_when_full", 128'(bus0.out_valid), 128'd1);
      fork
         begin
            for (int i = 32; i < 48; i++)
               applyStimulus(0, 32'h30 + 32'(i), 1'b0);
         end
         begin
            @(negedge clk);
            checkOutput("bp_still_stalled", 128'(bus0.in_ready), 128'd0);
            bus0.out_ready = 1'b1;
            @(negedge clk);
            checkOutput("bp_ready_after_pop", 128'(bus0.in_ready), 128'd1);
         end
      join
      drainWait("bp");

      // Push and pop on the same edge with one block buffered
      bus0.out_ready = 1'b0;
      sb0.push_back(mk(bytes_blk(8'h60), 1'b0, 16));
      sb0.push_back(mk(bytes_blk(8'h70), 1'b0, 16));
      for (int i = 0; i < 16; i++)
         applyStimulus(0, 32'h60 + 32'(i), 1'b0);
      for (int i = 0; i < 15; i++)
         applyStimulus(0, 32'h70 + 32'(i), 1'b0);
      checkOutput("pp_ready_before", 128'(bus0.in_ready), 128'd1);
      bus0.out_ready = 1'b1;
      applyStimulus(0, 32'h7F, 1'b0);
      checkOutput("pp_valid_after", 128'(bus0.out_valid), 128'd1);
      checkOutput("pp_ready_after", 128'(bus0.in_ready), 128'd1);
      @(negedge clk);
      checkOutput("pp_count_was_one", 128'(bus0.out_valid), 128'd0);
      drainWait("pp");

      // Reset with one block buffered and seven bytes in assembly
      bus0.out_ready = 1'b0;
      for (int i = 0; i < 16; i++)
         applyStimulus(0, 32'h80 + 32'(i), 1'b0);
      for (int i = 0; i < 7; i++)
         applyStimulus(0, 32'h90 + 32'(i), 1'b0);
      checkOutput("mid_buffered_valid", 128'(bus0.out_valid), 128'd1);
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 128'(bus0.out_valid), 128'd0);
      checkOutput("mid_rst_data",  bus0.out_data, 128'd0);
      checkOutput("mid_rst_last",  128'(bus0.out_last), 128'd0);
      checkOutput("mid_rst_ready", 128'(bus0.in_ready), 128'd1);
      @(negedge clk);
      reset = 1'b1;
      bus0.out_ready = 1'b1;
      sb0.push_back(mk(128'h000102030405060708090A0B0C0D0E0F, 1'b0, 16));
      for (int i = 0; i < 16; i++)
         applyStimulus(0, 32'(i), 1'b0);
      drainWait("mid_reset");
      checkOutput("mid_no_extra_block", 128'(bus0.out_valid), 128'd0);

      // PKCS#7 padding on 8-bit words
      sb1.push_back(mk(128'hA1A2A3A4A50B0B0B0B0B0B0B0B0B0B0B, 1'b1, 5));
      for (int i = 0; i < 5; i++)
         applyStimulus(1, 32'hA1 + 32'(i), (i == 4));
      sb1.push_back(mk(bytes_blk(8'h10), 1'b1, 16));
      for (int i = 0; i < 16; i++)
         applyStimulus(1, 32'h10 + 32'(i), (i == 15));
      sb1.push_back(mk(128'h770F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 1'b1, 1));
      applyStimulus(1, 32'h77, 1'b1);
      drainWait("pkcs8");

      // 32-bit words, LSB first, single-entry FIFO
      bus2.out_ready = 1'b0;
      sb2.push_back(mk(128'h44444444_33333333_22222222_11111111, 1'b0, 4));
      applyStimulus(2, 32'h11111111, 1'b0);
      applyStimulus(2, 32'h22222222, 1'b0);
      applyStimulus(2, 32'h33333333, 1'b0);
      applyStimulus(2, 32'h44444444, 1'b0);
      checkOutput("w32_ready_low_depth1", 128'(bus2.in_ready), 128'd0);
      checkOutput("w32_valid", 128'(bus2.out_valid), 128'd1);
      bus2.out_ready = 1'b1;
      @(negedge clk);
      checkOutput("w32_ready_after_pop", 128'(bus2.in_ready), 128'd1);
      sb2.push_back(mk(128'h08080808_08080808_01020304_AABBCCDD, 1'b1, 2));
      applyStimulus(2, 32'hAABBCCDD, 1'b0);
      applyStimulus(2, 32'h01020304, 1'b1);
      drainWait("w32");

      checkOutput("idle_data0", bus0.out_data, 128'd0);
      checkOutput("idle_data1", bus1.out_data, 128'd0);
      checkOutput("idle_data2", bus2.out_data, 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
